// File: rtl/poly_fir_stage2.sv
// poly_fir_stage2: decimate-by-4 low-pass FIR built on one sequential MAC over a circular sample RAM.
// Optional sticky status flags (sat_flag, overrun_flag, status_clr) are enabled by `define POLY_FIR_STAGE2_STATUS_EN.
module poly_fir_stage2 #(
    parameter int DECIMATION_FACTOR = 4,
    parameter int TAP_LEN           = 32,
    parameter int DATA_WIDTH        = 16,
    parameter int COEF_WIDTH        = 16,
    parameter int BUF_LEN           = 64,
    // Triangular-on-pedestal low-pass, coef[i] at bits [i*COEF_WIDTH +: COEF_WIDTH], sum 32768 (unity gain at >>>15)
    parameter logic [TAP_LEN*COEF_WIDTH-1:0] COEFS = {
        16'h0220, 16'h0260, 16'h02A0, 16'h02E0, 16'h0320, 16'h0360, 16'h03A0, 16'h03E0,
        16'h0420, 16'h0460, 16'h04A0, 16'h04E0, 16'h0520, 16'h0560, 16'h05A0, 16'h05E0,
        16'h05E0, 16'h05A0, 16'h0560, 16'h0520, 16'h04E0, 16'h04A0, 16'h0460, 16'h0420,
        16'h03E0, 16'h03A0, 16'h0360, 16'h0320, 16'h02E0, 16'h02A0, 16'h0260, 16'h0220
    }
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  din_valid,
    input  logic [DATA_WIDTH-1:0] din,
`ifdef POLY_FIR_STAGE2_STATUS_EN
    input  logic                  status_clr,
    output logic                  sat_flag,
    output logic                  overrun_flag,
`endif
    output logic                  dout_valid,
    output logic [DATA_WIDTH-1:0] dout
);

    localparam int ADDR_W = $clog2(BUF_LEN);
    localparam int TAP_W  = $clog2(TAP_LEN);
    localparam int FILL_W = $clog2(TAP_LEN + 1);
    localparam int PH_W   = (DECIMATION_FACTOR > 1) ? $clog2(DECIMATION_FACTOR) : 1;
    localparam int PROD_W = DATA_WIDTH + COEF_WIDTH;
    localparam int ACC_W  = PROD_W + $clog2(TAP_LEN);
    localparam logic signed [ACC_W-1:0] Y_MAX      = ACC_W'((2 ** (DATA_WIDTH - 1)) - 1);
    localparam logic signed [ACC_W-1:0] Y_MIN      = ~Y_MAX;
    localparam logic signed [ACC_W-1:0] ROUND_BIAS = ACC_W'(2 ** (COEF_WIDTH - 2));

    typedef enum logic [1:0] {IDLE, PRIME, MAC, DONE} state_t;

    state_t                  st, st_next;
    logic [DATA_WIDTH-1:0]   sram [BUF_LEN];
    logic [DATA_WIDTH-1:0]   rd_data;
    logic [ADDR_W-1:0]       wr_ptr, rd_addr;
    logic [PH_W-1:0]         phase_cnt;
    logic [FILL_W-1:0]       fill_cnt, fill_next, fill_cap;
    logic [TAP_W-1:0]        tap;
    logic signed [ACC_W-1:0] acc, prod_ext, rounded, shifted;
    logic signed [DATA_WIDTH-1:0] gated, y;
    logic signed [COEF_WIDTH-1:0] coef;
    logic signed [PROD_W-1:0]     prod;
    logic                    trigger;

    assign trigger   = din_valid && (phase_cnt == PH_W'(DECIMATION_FACTOR - 1));
    assign fill_next = (fill_cnt == FILL_W'(TAP_LEN)) ? fill_cnt : fill_cnt + FILL_W'(1);

    // Sample RAM is never reset; fill_cap masks whatever history predates the last reset.
    always_ff @(posedge clk) begin
        if (din_valid) begin
            sram[wr_ptr] <= din;
        end
        rd_data <= sram[rd_addr];
    end

    always_comb begin
        coef     = COEFS[int'(tap) * COEF_WIDTH +: COEF_WIDTH];
        gated    = (FILL_W'(tap) < fill_cap) ? rd_data : '0;
        prod     = gated * coef;
        prod_ext = {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
        rounded  = acc + ROUND_BIAS;
        shifted  = rounded >>> (COEF_WIDTH - 1);
        if (shifted > Y_MAX) begin
            y = Y_MAX[DATA_WIDTH-1:0];
        end else if (shifted < Y_MIN) begin
            y = Y_MIN[DATA_WIDTH-1:0];
        end else begin
            y = shifted[DATA_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st <= IDLE;
        end else begin
            st <= st_next;
        end
    end

    // Triggers outside IDLE fall through unchanged: the running computation always completes.
    always_comb begin
        st_next = st;
        case (st)
            IDLE:    if (trigger) st_next = PRIME;
            PRIME:   st_next = MAC;
            MAC:     if (tap == TAP_W'(TAP_LEN - 1)) st_next = DONE;
            DONE:    st_next = IDLE;
            default: st_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_addr    <= '0;
            phase_cnt  <= '0;
            fill_cnt   <= '0;
            fill_cap   <= '0;
            tap        <= '0;
            acc        <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
        end else begin
            dout_valid <= 1'b0;
            if (din_valid) begin
                wr_ptr    <= (wr_ptr == ADDR_W'(BUF_LEN - 1)) ? '0 : wr_ptr + ADDR_W'(1);
                phase_cnt <= (phase_cnt == PH_W'(DECIMATION_FACTOR - 1)) ? '0 : phase_cnt + PH_W'(1);
                fill_cnt  <= fill_next;
            end
            // The read address walks backwards from the trigger sample, so tap 0 is the newest sample.
            case (st)
                IDLE: begin
                    if (trigger) begin
                        rd_addr  <= wr_ptr;
                        tap      <= '0;
                        acc      <= '0;
                        fill_cap <= fill_next;
                    end
                end
                PRIME: begin
                    rd_addr <= (rd_addr == '0) ? ADDR_W'(BUF_LEN - 1) : rd_addr - ADDR_W'(1);
                end
                MAC: begin
                    acc     <= acc + prod_ext;
                    tap     <= tap + TAP_W'(1);
                    rd_addr <= (rd_addr == '0) ? ADDR_W'(BUF_LEN - 1) : rd_addr - ADDR_W'(1);
                end
                DONE: begin
                    dout       <= y;
                    dout_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef POLY_FIR_STAGE2_STATUS_EN
    // Sticky flags: a set event in the same cycle as status_clr keeps the flag high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_flag     <= 1'b0;
            overrun_flag <= 1'b0;
        end else begin
            if (st == DONE && (shifted > Y_MAX || shifted < Y_MIN)) begin
                sat_flag <= 1'b1;
            end else if (status_clr) begin
                sat_flag <= 1'b0;
            end
            if (trigger && st != IDLE) begin
                overrun_flag <= 1'b1;
            end else if (status_clr) begin
                overrun_flag <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_poly_fir_stage2.sv
// Self-checking bench for poly_fir_stage2: table-driven impulse/DC vectors plus overrun, reset-abort and saturation sequences.
module tb_poly_fir_stage2;

    localparam int TAPS = 32;

    typedef struct {
        int  din;
        bit  chk;
        int  exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        din_valid;
    logic [15:0] din;
    logic        dout_valid, sat_dout_valid;
    logic [15:0] dout, sat_dout;
`ifdef POLY_FIR_STAGE2_STATUS_EN
    logic        status_clr;
    logic        sat_flag, overrun_flag, s_sat_flag, s_overrun_flag;
`endif

    int checks = 0;
    int errors = 0;
    int coefTb [TAPS];
    int histQ [$];
    int expQ [$];
    int total;
    bit monEn = 1'b0;
    int monCount = 0;

    always #5 clk = ~clk;

    poly_fir_stage2 dut (
        .clk(clk), .rst_n(rst_n), .din_valid(din_valid), .din(din),
`ifdef POLY_FIR_STAGE2_STATUS_EN
        .status_clr(status_clr), .sat_flag(sat_flag), .overrun_flag(overrun_flag),
`endif
        .dout_valid(dout_valid), .dout(dout)
    );

    // Second instance with coefficients summing to 40000 so full-scale input must clamp.
    poly_fir_stage2 #(.COEFS({32{16'd1250}})) sat_dut (
        .clk(clk), .rst_n(rst_n), .din_valid(din_valid), .din(din),
`ifdef POLY_FIR_STAGE2_STATUS_EN
        .status_clr(status_clr), .sat_flag(s_sat_flag), .overrun_flag(s_overrun_flag),
`endif
        .dout_valid(sat_dout_valid), .dout(sat_dout)
    );

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, required %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int value);
        @(negedge clk);
        din       = 16'(value);
        din_valid = 1'b1;
        @(negedge clk);
        din_valid = 1'b0;
        din       = '0;
    endtask

    task automatic waitOutput(output int cycles);
        cycles = 0;
        while (cycles < 60) begin
            @(negedge clk);
            cycles++;
            if (dout_valid) return;
        end
        checks++;
        errors++;
        $display("[TB] FAIL output timeout: no dout_valid within %0d cycles, required one", cycles);
    endtask

    task automatic doReset();
        rst_n     = 1'b0;
        din_valid = 1'b0;
        din       = '0;
`ifdef POLY_FIR_STAGE2_STATUS_EN
        status_clr = 1'b0;
`endif
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    function automatic int modelOut();
        longint sum = 0;
        int n = (total < TAPS) ? total : TAPS;
        for (int j = 0; j < n; j++) sum += longint'(histQ[j]) * coefTb[j];
        sum = (sum + 16384) >>> 15;
        if (sum > 32767) sum = 32767;
        if (sum < -32768) sum = -32768;
        return int'(sum);
    endfunction

    // Compares every output strobe against the queue of model results while enabled.
    always @(negedge clk) begin
        if (monEn && dout_valid) begin
            monCount++;
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL overrun extra output: got %0d, required no output", $signed(dout));
            end else begin
                checkOutput("overrun output", $signed(dout), expQ.pop_front());
            end
        end
    end

    initial begin
        vec_t impulseVec [40];
        vec_t dcVec [40];
        int impExp [10] = '{368, 496, 624, 752, 656, 528, 400, 272, 0, 0};
        int dcExp  [10] = '{78, 188, 328, 500, 672, 813, 922, 1000, 1000, 1000};
        int cyc, pulses, busyUntil, accepted;

        for (int i = 0; i < TAPS; i++) begin
            coefTb[i] = 64 * (((i + 1) < (TAPS - i)) ? (i + 1) : (TAPS - i)) + 480;
        end
        for (int i = 0; i < 40; i++) begin
            impulseVec[i] = '{(i == 0) ? 16384 : 0, (i % 4 == 3), (i % 4 == 3) ? impExp[i / 4] : 0};
            dcVec[i]      = '{1000, (i % 4 == 3), (i % 4 == 3) ? dcExp[i / 4] : 0};
        end

        rst_n     = 1'b0;
        din_valid = 1'b0;
        din       = '0;
`ifdef POLY_FIR_STAGE2_STATUS_EN
        status_clr = 1'b0;
`endif
        #1;
        checkOutput("reset dout", $signed(dout), 0);
        checkOutput("reset dout_valid", dout_valid, 0);

        // Impulse response, with latency, strobe width and hold checked on the first output.
        doReset();
        for (int i = 0; i < 40; i++) begin
            applyStimulus(impulseVec[i].din);
            if (impulseVec[i].chk) begin
                waitOutput(cyc);
                checkOutput($sformatf("impulse out %0d", i / 4), $signed(dout), impulseVec[i].exp);
                if (i == 3) begin
                    checkOutput("latency cycles", cyc, 34);
                    @(negedge clk);
                    checkOutput("strobe width", dout_valid, 0);
                    checkOutput("dout hold", $signed(dout), 368);
                end
            end
        end

        // DC ramp: pre-fill history counts as zero, then unity gain.
        doReset();
        for (int i = 0; i < 40; i++) begin
            applyStimulus(dcVec[i].din);
            if (dcVec[i].chk) begin
                waitOutput(cyc);
                checkOutput($sformatf("dc out %0d", i / 4), $signed(dout), dcVec[i].exp);
            end
        end

        // Overrun: din_valid every cycle, triggers during a computation are dropped.
        doReset();
        histQ.delete();
        expQ.delete();
        total = 0;
        busyUntil = 0;
        accepted = 0;
        monCount = 0;
        monEn = 1'b1;
        for (int e = 0; e < 120; e++) begin
            @(negedge clk);
            din_valid = 1'b1;
            din = 16'(((e * 1237) % 20000) - 10000);
            histQ.push_front(((e * 1237) % 20000) - 10000);
            if (histQ.size() > TAPS) void'(histQ.pop_back());
            total++;
            if (total % 4 == 0 && e >= busyUntil) begin
                expQ.push_back(modelOut());
                busyUntil = e + 35;
                accepted++;
            end
        end
        @(negedge clk);
        din_valid = 1'b0;
        repeat (45) @(negedge clk);
        monEn = 1'b0;
        checkOutput("overrun pending outputs", expQ.size(), 0);
        checkOutput("overrun output count", monCount, accepted);
`ifdef POLY_FIR_STAGE2_STATUS_EN
        checkOutput("overrun_flag set", overrun_flag, 1);
        checkOutput("sat_flag idle", sat_flag, 0);
        @(negedge clk) status_clr = 1'b1;
        @(negedge clk) status_clr = 1'b0;
        checkOutput("overrun_flag cleared", overrun_flag, 0);
`endif

        // Reset asserted mid-MAC aborts the output; later output uses only new samples.
        doReset();
        for (int i = 0; i < 4; i++) applyStimulus(4000);
        waitOutput(cyc);
        checkOutput("pre-abort output", $signed(dout), 313);
        for (int i = 0; i < 4; i++) applyStimulus(4000);
        repeat (11) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("abort dout", $signed(dout), 0);
        checkOutput("abort dout_valid", dout_valid, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (dout_valid) pulses++;
        end
        checkOutput("no output after abort", pulses, 0);
        applyStimulus(3000);
        applyStimulus(-2000);
        applyStimulus(500);
        applyStimulus(7000);
        waitOutput(cyc);
        checkOutput("post-abort output", $signed(dout), 152);

        // Saturation with the high-gain instance, positive then negative full scale.
        doReset();
        for (int i = 0; i < 32; i++) begin
            applyStimulus(32767);
            if (i % 4 == 3) begin
                waitOutput(cyc);
                if (i == 3) checkOutput("sat first output", $signed(sat_dout), 5000);
            end
        end
        checkOutput("sat strobe", sat_dout_valid, 1);
        checkOutput("sat positive clamp", $signed(sat_dout), 32767);
        checkOutput("unity full scale", $signed(dout), 32767);
`ifdef POLY_FIR_STAGE2_STATUS_EN
        checkOutput("sat_flag set", s_sat_flag, 1);
        checkOutput("sat_flag unity", sat_flag, 0);
        @(negedge clk) status_clr = 1'b1;
        @(negedge clk) status_clr = 1'b0;
        checkOutput("sat_flag cleared", s_sat_flag, 0);
`endif
        for (int i = 0; i < 32; i++) begin
            applyStimulus(-32768);
            if (i % 4 == 3) waitOutput(cyc);
        end
        checkOutput("sat negative clamp", $signed(sat_dout), -32768);
        checkOutput("unity negative full scale", $signed(dout), -32768);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
